// File: rtl/ro_puf_pkg.sv
// Shared types and defaults for the ring-oscillator PUF measurement blocks.
package ro_puf_pkg;

  localparam int CHAL_W     = 8;
  localparam int DEF_WINDOW = 256;
  localparam int DEF_SETTLE = 4;
  localparam int DEF_CNT_W  = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_A,
    COUNT_A,
    SETTLE_B,
    COUNT_B,
    COMPARE,
    DONE
  } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes an asynchronous oscillator output and counts its rising edges
// into a saturating counter with synchronous clear and count enable.
module ro_edge_counter #(
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   synced_d;
  logic                   rise;

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~synced_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      synced_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ro_in};
      synced_d <= synced;
    end
  end

  // Saturate rather than wrap so a very fast oscillator never reads as slow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && rise && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_puf_response_gen.sv
// Response generator for the F2G ring-oscillator PUF: measures each challenge
// against its complement and assembles a RESP_BITS-wide response word.
module ro_puf_response_gen
  import ro_puf_pkg::*;
#(
  parameter int WINDOW      = DEF_WINDOW,
  parameter int SETTLE      = DEF_SETTLE,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RESP_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    chal_seed,
  input  logic                 s_cfg,
  input  logic                 ro_out,
  output logic                 ro_enable,
  output logic                 ro_s,
  output logic [CHAL_W-1:0]    ro_c,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp,
  output logic [RESP_BITS-1:0] resp_tie,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output state_t               dbg_state
);

  localparam int TMR_W = $clog2(((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1);

  state_t            state, state_d;
  logic [TMR_W-1:0]  tmr;
  logic [CHAL_W-1:0] seed, idx;
  logic [CNT_W-1:0]  cnt_live, cnt_a;
  logic              phase_end, cnt_clr, cnt_en;

  assign dbg_state = state;
  assign cnt_clr   = ((state == SETTLE_A) || (state == SETTLE_B)) && phase_end;
  assign cnt_en    = (state == COUNT_A) || (state == COUNT_B);

  ro_edge_counter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ro_in (ro_out),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt_live)
  );

  always_comb begin
    phase_end = 1'b0;
    case (state)
      SETTLE_A, SETTLE_B: phase_end = (tmr == TMR_W'(SETTLE - 1));
      COUNT_A, COUNT_B:   phase_end = (tmr == TMR_W'(WINDOW - 1));
      default:            phase_end = 1'b0;
    endcase
  end

  // Handshake: resp/resp_tie are held while resp_valid is high; the word is
  // transferred on a clock edge where resp_valid && resp_ready, after which
  // resp_valid drops and the block returns to IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start) state_d = SETTLE_A;
      SETTLE_A: if (phase_end) state_d = COUNT_A;
      COUNT_A:  if (phase_end) state_d = SETTLE_B;
      SETTLE_B: if (phase_end) state_d = COUNT_B;
      COUNT_B:  if (phase_end) state_d = COMPARE;
      COMPARE:  state_d = (idx == CHAL_W'(RESP_BITS - 1)) ? DONE : SETTLE_A;
      DONE:     if (resp_valid && resp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tmr        <= '0;
      seed       <= '0;
      idx        <= '0;
      cnt_a      <= '0;
      ro_enable  <= 1'b0;
      ro_s       <= 1'b0;
      ro_c       <= '0;
      busy       <= 1'b0;
      resp       <= '0;
      resp_tie   <= '0;
      resp_valid <= 1'b0;
    end else begin
      state <= state_d;
      tmr   <= (state_d == state) ? tmr + TMR_W'(1) : '0;
      busy  <= (state_d != IDLE);
      case (state)
        IDLE: if (start) begin
          seed     <= chal_seed;
          ro_s     <= s_cfg;
          ro_c     <= chal_seed;
          idx      <= '0;
          resp     <= '0;
          resp_tie <= '0;
        end
        SETTLE_A: if (phase_end) ro_enable <= 1'b1;
        COUNT_A: if (phase_end) begin
          ro_enable <= 1'b0;
          ro_c      <= ~(seed ^ idx);
        end
        SETTLE_B: begin
          // The A window is closed and the counter is not cleared until the
          // end of this phase, so the first cycle holds the final A count.
          if (tmr == '0) cnt_a <= cnt_live;
          if (phase_end) ro_enable <= 1'b1;
        end
        COUNT_B: if (phase_end) ro_enable <= 1'b0;
        COMPARE: begin
          for (int b = 0; b < RESP_BITS; b++) begin
            if (idx == CHAL_W'(b)) begin
              resp[b]     <= (cnt_a > cnt_live);
              resp_tie[b] <= (cnt_a == cnt_live);
            end
          end
          if (idx != CHAL_W'(RESP_BITS - 1)) begin
            idx  <= idx + CHAL_W'(1);
            ro_c <= seed ^ (idx + CHAL_W'(1));
          end
        end
        DONE: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            ro_s       <= 1'b0;
          end else begin
            resp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Bench for ro_puf_response_gen: three configurations share one oscillator
// model; expected responses come from recorded ro_out rise times and windows.
module tb_ro_puf_response_gen;
  import ro_puf_pkg::*;

  localparam int SYNC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  int         sel;
  logic       start, s_cfg, ro_sig, resp_ready;
  logic [7:0] chal_seed;
  logic       st0, st1, st2;
  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  int rb_t [3] = '{4, 16, 4};
  int w_t  [3] = '{60, 256, 60};
  int s_t  [3] = '{4, 4, 4};
  int cw_t [3] = '{10, 10, 3};

  // ---------------- DUT instances ----------------
  logic en0, rs0, bz0, v0; logic [7:0] c0; logic [3:0]  r0, t0; state_t q0;
  logic en1, rs1, bz1, v1; logic [7:0] c1; logic [15:0] r1, t1; state_t q1;
  logic en2, rs2, bz2, v2; logic [7:0] c2; logic [3:0]  r2, t2; state_t q2;

  ro_puf_response_gen #(.WINDOW(60), .SETTLE(4), .CNT_W(10), .RESP_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(st0), .chal_seed(chal_seed), .s_cfg(s_cfg),
    .ro_out(ro_sig), .ro_enable(en0), .ro_s(rs0), .ro_c(c0), .busy(bz0),
    .resp(r0), .resp_tie(t0), .resp_valid(v0), .resp_ready(resp_ready), .dbg_state(q0));

  ro_puf_response_gen dut_def (
    .clk(clk), .rst_n(rst_n), .start(st1), .chal_seed(chal_seed), .s_cfg(s_cfg),
    .ro_out(ro_sig), .ro_enable(en1), .ro_s(rs1), .ro_c(c1), .busy(bz1),
    .resp(r1), .resp_tie(t1), .resp_valid(v1), .resp_ready(resp_ready), .dbg_state(q1));

  ro_puf_response_gen #(.WINDOW(60), .SETTLE(4), .CNT_W(3), .RESP_BITS(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(st2), .chal_seed(chal_seed), .s_cfg(s_cfg),
    .ro_out(ro_sig), .ro_enable(en2), .ro_s(rs2), .ro_c(c2), .busy(bz2),
    .resp(r2), .resp_tie(t2), .resp_valid(v2), .resp_ready(resp_ready), .dbg_state(q2));

  logic        m_en, m_ro_s, m_busy, m_valid;
  logic [7:0]  m_ro_c;
  logic [15:0] m_resp, m_tie;
  state_t      m_state;
  assign m_en    = (sel == 0) ? en0 : (sel == 1) ? en1 : en2;
  assign m_ro_s  = (sel == 0) ? rs0 : (sel == 1) ? rs1 : rs2;
  assign m_busy  = (sel == 0) ? bz0 : (sel == 1) ? bz1 : bz2;
  assign m_valid = (sel == 0) ? v0  : (sel == 1) ? v1  : v2;
  assign m_ro_c  = (sel == 0) ? c0  : (sel == 1) ? c1  : c2;
  assign m_resp  = (sel == 0) ? {12'h0, r0} : (sel == 1) ? r1 : {12'h0, r2};
  assign m_tie   = (sel == 0) ? {12'h0, t0} : (sel == 1) ? t1 : {12'h0, t2};
  assign m_state = (sel == 0) ? q0  : (sel == 1) ? q1  : q2;

  // ---------------- oscillator model ----------------
  // mode 0: stuck low; 1: half-period 3/5 by ro_c[0]; 2: random per challenge;
  // 3: toggles every cycle. Phase restarts whenever the challenge changes.
  int         mode;
  int         hp_tab [256];
  int         rise_q [$];
  initial begin
    int         hp;
    int         ph;
    logic [7:0] last_c;
    ro_sig = 1'b0;
    ph     = 0;
    last_c = 8'h00;
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        ro_sig = 1'b0;
      end else begin
        hp = (mode == 1) ? (m_ro_c[0] ? 5 : 3) : (mode == 2) ? hp_tab[m_ro_c] : 1;
        if (m_ro_c != last_c) begin
          ph     = 0;
          last_c = m_ro_c;
        end
        ph++;
        if (ph >= hp) begin
          ph     = 0;
          ro_sig = ~ro_sig;
          if (ro_sig) rise_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] last_er, last_et;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rises whose synchronized detect pulse lands inside the window starting at w0.
  function automatic int cnt_win(input int w0, input int w, input int cw);
    int n;
    int mx;
    n  = 0;
    mx = (1 << cw) - 1;
    foreach (rise_q[i]) if (rise_q[i] >= w0 - SYNC && rise_q[i] <= w0 + w - 1 - SYNC) n++;
    return (n > mx) ? mx : n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [7:0] sd, input logic sc, output int e0);
    chal_seed = sd;
    s_cfg     = sc;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0    = cyc;
  endtask

  task automatic measure(input logic [7:0] sd, input logic sc, input int e0);
    int          rb, w, s, cw, p, lat, ca, cb, bi, off;
    logic [7:0]  prev_c, ec, eb;
    logic [15:0] er, et;
    bit          got;
    rb = rb_t[sel]; w = w_t[sel]; s = s_t[sel]; cw = cw_t[sel];
    p = 2 * s + 2 * w + 1;
    prev_c = m_ro_c;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k <= rb * p + 8; k++) begin
      if (k > 0) @(negedge clk);
      if (m_valid) begin
        got = 1'b1;
        lat = k;
        break;
      end
      bi  = k / p;
      off = k % p;
      ec  = sd ^ 8'(bi);
      eb  = ~ec;
      if (m_ro_c !== prev_c) chk("ro_c_changed_while_enabled", {31'b0, m_en}, 32'd0);
      prev_c = m_ro_c;
      if (bi < rb) begin
        if (off == s - 1) begin
          chk("ro_c_chal_a", {24'b0, m_ro_c}, {24'b0, ec});
          chk("enable_in_settle", {31'b0, m_en}, 32'd0);
        end
        if (off == 2 * s + w - 1) chk("ro_c_chal_b", {24'b0, m_ro_c}, {24'b0, eb});
        if (off == s || off == 2 * s + w) chk("enable_in_count", {31'b0, m_en}, 32'd1);
        if (off == 0) begin
          chk("busy_measuring", {31'b0, m_busy}, 32'd1);
          chk("ro_s_measuring", {31'b0, m_ro_s}, {31'b0, sc});
        end
      end
    end
    chk("resp_valid_seen", {31'b0, got}, 32'd1);
    chk("latency", lat, rb * p + 1);
    er = '0;
    et = '0;
    for (int b = 0; b < rb; b++) begin
      ca = cnt_win(e0 + b * p + s, w, cw);
      cb = cnt_win(e0 + b * p + 2 * s + w, w, cw);
      er[b] = (ca > cb);
      et[b] = (ca == cb);
    end
    chk("resp", {16'b0, m_resp}, {16'b0, er});
    chk("resp_tie", {16'b0, m_tie}, {16'b0, et});
    chk("ro_s_done", {31'b0, m_ro_s}, {31'b0, sc});
    last_er = er;
    last_et = et;
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_after_ack", {31'b0, m_valid}, 32'd0);
    chk("busy_after_ack", {31'b0, m_busy}, 32'd0);
    chk("ro_s_idle", {31'b0, m_ro_s}, 32'd0);
    chk("resp_retained", {16'b0, m_resp}, {16'b0, last_er});
    chk("tie_retained", {16'b0, m_tie}, {16'b0, last_et});
    chk("state_idle", 32'(m_state), 32'(IDLE));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ro_enable"}, {31'b0, m_en}, 32'd0);
    chk({tag, "_busy"}, {31'b0, m_busy}, 32'd0);
    chk({tag, "_valid"}, {31'b0, m_valid}, 32'd0);
    chk({tag, "_ro_s"}, {31'b0, m_ro_s}, 32'd0);
    chk({tag, "_ro_c"}, {24'b0, m_ro_c}, 32'd0);
    chk({tag, "_resp"}, {16'b0, m_resp}, 32'd0);
    chk({tag, "_tie"}, {16'b0, m_tie}, 32'd0);
    chk({tag, "_state"}, 32'(m_state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         e0;
    logic [7:0] sd;
    logic       sc;
    sel = 0; start = 1'b0; resp_ready = 1'b0; chal_seed = 8'h00; s_cfg = 1'b0; mode = 1;
    for (int i = 0; i < 256; i++) hp_tab[i] = $urandom_range(1, 8);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk_zero("reset");
    end
    sel = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // Test-plan pattern: seed 0, 3/5 half-periods -> 4'b0101, no ties.
    mode = 1;
    launch(8'h00, 1'b1, e0);
    measure(8'h00, 1'b1, e0);
    chk("resp_directed", {16'b0, m_resp}, 32'h5);
    chk("tie_directed", {16'b0, m_tie}, 32'h0);
    ack();

    // Challenge sequence A5, 5A, A4, 5B, ...
    launch(8'hA5, 1'b0, e0);
    measure(8'hA5, 1'b0, e0);
    ack();

    // Random challenge-dependent oscillator speeds.
    mode = 2;
    repeat (3) begin
      sd = 8'($urandom_range(0, 255));
      sc = 1'($urandom_range(0, 1));
      launch(sd, sc, e0);
      measure(sd, sc, e0);
      ack();
    end

    // Consumer stalls in DONE; start pulses are ignored.
    sd = 8'($urandom_range(0, 255));
    launch(sd, 1'b1, e0);
    measure(sd, 1'b1, e0);
    for (int k = 0; k < 20; k++) begin
      start = (k == 5);
      @(negedge clk);
      chk("valid_held", {31'b0, m_valid}, 32'd1);
      chk("resp_held", {16'b0, m_resp}, {16'b0, last_er});
      chk("state_held_done", 32'(m_state), 32'(DONE));
    end
    resp_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("valid_drop", {31'b0, m_valid}, 32'd0);
    chk("start_on_exit_ignored", {31'b0, m_busy}, 32'd0);
    chk("resp_kept", {16'b0, m_resp}, {16'b0, last_er});
    launch(sd, 1'b0, e0);
    measure(sd, 1'b0, e0);
    ack();

    // Reset in the middle of COUNT_B of bit 2.
    mode = 1;
    launch(8'h3C, 1'b1, e0);
    repeat (2 * 129 + 2 * 4 + 60 + 10) @(negedge clk);
    chk("enable_before_reset", {31'b0, m_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(8'h3C, 1'b1, e0);
    measure(8'h3C, 1'b1, e0);
    chk("resp_after_reset", {16'b0, m_resp}, 32'h5);
    ack();

    // Stuck oscillator on the default configuration: every bit ties.
    sel = 1;
    mode = 0;
    @(negedge clk);
    sd = 8'($urandom_range(0, 255));
    launch(sd, 1'b1, e0);
    measure(sd, 1'b1, e0);
    chk("resp_stuck", {16'b0, m_resp}, 32'h0);
    chk("tie_stuck", {16'b0, m_tie}, 32'hFFFF);
    ack();

    // 3-bit counter with a fast oscillator: both counts saturate at 7.
    sel = 2;
    mode = 3;
    @(negedge clk);
    launch(8'h12, 1'b0, e0);
    measure(8'h12, 1'b0, e0);
    chk("resp_saturated", {16'b0, m_resp}, 32'h0);
    chk("tie_saturated", {16'b0, m_tie}, 32'hF);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
